// File: rtl/bcd_score_display_if.sv
// ============================================================================
// bcd_score_display_if : score bus between a BCD score source and the display
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bcd_score_display_if;
   logic [15:0] bcd_in;
   logic        load;
   logic        busy;
   logic [6:0]  hex0;
   logic [6:0]  hex1;
   logic [6:0]  hex2;
   logic [6:0]  hex3;

   modport master (
      output bcd_in, load,
      input  busy, hex0, hex1, hex2, hex3
   );

   modport slave (
      input  bcd_in, load,
      output busy, hex0, hex1, hex2, hex3
   );
endinterface

`default_nettype wire

// File: rtl/bcd_score_display.sv
// ============================================================================
// bcd_score_display : rolling 4-digit BCD score on active-low 7-seg digits
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (hex3..hex1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_score_display #(
   parameter int STEP_DIV = 2500000
) (
   input  wire logic          clk,
   input  wire logic          reset,
   bcd_score_display_if.slave bus
);

   localparam int PRESC_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(STEP_DIV - 1);

   logic [15:0]        target;
   logic [15:0]        disp;
   logic [PRESC_W-1:0] presc;
   logic [6:0]         seg [4];

   function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++) begin
         if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Compare/step decisions use the pre-edge target, so a load only affects
   // disp from the following edge onward.
   always_ff @(posedge clk) begin
      if (reset) begin
         target <= 16'h0000;
         disp   <= 16'h0000;
         presc  <= '0;
      end else begin
         if (bus.load) target <= bcd_clamp(bus.bcd_in);

         if (target < disp) begin
            disp  <= target;
            presc <= '0;
         end else if (target > disp) begin
            if (presc == PRESC_MAX) begin
               presc <= '0;
               disp  <= bcd_inc(disp);
            end else begin
               presc <= presc + 1'b1;
            end
         end else begin
            presc <= '0;
         end
      end
   end

   assign bus.busy = (target != disp);

   for (genvar d = 0; d < 4; d++) begin : g_digit
      if (d == 0) begin : g_ones
         assign seg[d] = seg7(disp[3:0]);
      end else begin : g_upper
`ifdef LEADING_ZERO_BLANK_EN
         assign seg[d] = (disp[15:4*d] == '0) ? 7'h7F : seg7(disp[4*d +: 4]);
`else
         assign seg[d] = seg7(disp[4*d +: 4]);
`endif
      end
   end

   assign bus.hex0 = seg[0];
   assign bus.hex1 = seg[1];
   assign bus.hex2 = seg[2];
   assign bus.hex3 = seg[3];

endmodule

`default_nettype wire

// File: tb/tb_bcd_score_display.sv
// ============================================================================
// tb_bcd_score_display : directed bench for bcd_score_display (STEP_DIV = 4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_score_display;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   bcd_score_display_if bus ();

   bcd_score_display #(.STEP_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Expected {hex3,hex2,hex1,hex0} for a given displayed BCD value.
   function automatic logic [27:0] exp_hex(input logic [15:0] v);
      logic [6:0] h [4];
      for (int i = 0; i < 4; i++) h[i] = seg_tab[int'(v[4*i +: 4])];
`ifdef LEADING_ZERO_BLANK_EN
      if (v[15:12] == 4'h0)  h[3] = 7'h7F;
      if (v[15:8]  == 8'h00) h[2] = 7'h7F;
      if (v[15:4]  == 12'h0) h[1] = 7'h7F;
`endif
      return {h[3], h[2], h[1], h[0]};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      bus.bcd_in = v;
      bus.load   = 1'b1;
      tick(1);
      bus.load   = 1'b0;
   endtask

   task automatic check(input string tag, input logic [15:0] d, input logic b);
      logic [27:0] e;
      logic [27:0] o;
      e = exp_hex(d);
      o = {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
      vectors++;
      assert (bus.busy === b) else begin
         miscompares++;
         $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, b);
      end
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s hex3..0 observed=%h expected=%h (disp %h)", tag, o, e, d);
      end
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles && bus.busy === 1'b1; i++) tick(1);
      vectors++;
      assert (bus.busy === 1'b0) else begin
         miscompares++;
         $error("FAIL %s idle-timeout observed busy=%b expected=0", tag, bus.busy);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      bus.load    = 1'b0;
      bus.bcd_in  = 16'h0000;

      tick(2);
      check("reset", 16'h0000, 1'b0);
      reset = 1'b0;

      // count-up to 3, one step per 4 cycles
      do_load(16'h0003);
      check("cnt_n0", 16'h0000, 1'b1);
      tick(3);  check("cnt_n3",  16'h0000, 1'b1);
      tick(1);  check("cnt_n4",  16'h0001, 1'b1);
      tick(4);  check("cnt_n8",  16'h0002, 1'b1);
      tick(3);  check("cnt_n11", 16'h0002, 1'b1);
      tick(1);  check("cnt_n12", 16'h0003, 1'b0);
      tick(4);  check("cnt_hold", 16'h0003, 1'b0);

      // BCD carry across three digits
      do_load(16'h0999);
      wait_idle("carry_999", 5000);
      check("carry_999", 16'h0999, 1'b0);
      do_load(16'h1000);
      tick(3);  check("carry_n3", 16'h0999, 1'b1);
      tick(1);  check("carry_n4", 16'h1000, 1'b0);

      // snap down
      do_load(16'h0010);
      check("snap1_n0", 16'h1000, 1'b1);
      tick(1);  check("snap1_n1", 16'h0010, 1'b0);
      do_load(16'h0005);
      check("snap2_n0", 16'h0010, 1'b1);
      tick(1);  check("snap2_n1", 16'h0005, 1'b0);

      // clamp and mid-count load below disp
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("rst2", 16'h0000, 1'b0);
      do_load(16'h00AF);
      tick(7);  check("clamp_n7", 16'h0001, 1'b1);
      tick(1);  check("clamp_n8", 16'h0002, 1'b1);
      do_load(16'h0001);
      check("mid_n9", 16'h0002, 1'b1);
      tick(1);  check("mid_n10", 16'h0001, 1'b0);
      do_load(16'h00AF);
      wait_idle("clamp_99", 1000);
      check("clamp_99", 16'h0099, 1'b0);
      do_load(16'h00F3);
      tick(1);  check("clamp_f3", 16'h0093, 1'b0);

      // load equal to disp keeps busy low
      do_load(16'h0093);
      check("equal", 16'h0093, 1'b0);

      // reset mid-count
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      do_load(16'h0009);
      tick(20); check("rmid_n20", 16'h0005, 1'b1);
      reset = 1'b1;
      tick(1);  check("rmid_rst", 16'h0000, 1'b0);
      reset = 1'b0;
      tick(8);  check("rmid_after", 16'h0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
